// File: rtl/vdff_rx_fifo.sv
// Receive-side FWFT FIFO at the consuming end of a vdff pipeline.
// Valid/ready on both sides; sticky ovf flags a producer that withdrew a stalled word.
module vdff_rx_fifo #(
  parameter int size  = 5,
  parameter int depth = 4,
  parameter int aw    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [0:size-1] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [0:size-1] out_data,
  input  logic            out_ready,
  output logic [aw:0]     count,
  output logic            ovf
);

  localparam logic [aw:0] full_count = (aw + 1)'(depth);

  logic [0:size-1] mem [depth];
  logic [aw-1:0]   wr_ptr;
  logic [aw-1:0]   rd_ptr;
  logic            stall_q;
  logic            push;
  logic            pop;

  // Ready is decoded from registered count only, so out_ready never reaches in_ready.
  assign in_ready  = (count != full_count);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      stall_q <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      stall_q <= in_valid & ~in_ready;
      if (stall_q && !in_valid) ovf <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; count/out_valid gate it, and a reset would bloat the array.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: doc/vdff_rx_fifo.md
Name: vdff_rx_fifo

Overview:
- Receive-side buffer for width-parameterised registered datapaths built from vdff-style stages.
- Accepts words from an upstream registered producer through a valid/ready handshake and holds them in a small circular FIFO.
- Presents the words to a downstream consumer in first-word-fall-through order.
- Sits at the consuming end of a vdff pipeline and decouples producer timing from consumer stalls.

Parameters:
- size, 5, data word width in bits; must be >= 1.
- depth, 4, number of FIFO entries; must be a power of two, >= 2.
- aw, 2, pointer width; must equal log2(depth).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a word on in_data.
- in_data  input  [0:size-1]  producer word, bit 0 is MSB.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_valid  output  1  out_data holds the oldest stored word.
- out_data  output  [0:size-1]  head-of-FIFO word.
- out_ready  input  1  consumer takes the word this cycle.
- count  output  [aw:0]  number of stored words, 0..depth.
- ovf  output  1  sticky: producer dropped in_valid before its word was accepted.

Behaviour:
- One clock, clk. rst is asynchronous and active-high: asserting rst immediately clears all state.
- Reset values: count=0, out_valid=0, in_ready=1, ovf=0, read pointer=0, write pointer=0. out_data is don't-care while out_valid=0.
- Push = in_valid & in_ready, sampled at the rising edge of clk.
- Pop = out_valid & out_ready, sampled at the rising edge of clk.
- in_ready = (count != depth), decoded from the registered count. A pop in the same cycle does not free a slot for that cycle's push, so there is no combinational ready path from out_ready to in_ready.
- out_valid = (count != 0).
- out_data = mem[rd_ptr], combinational read (first-word-fall-through).
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N, so it can be popped at edge N+1.
- Push: mem[wr_ptr] <= in_data; wr_ptr increments modulo depth.
- Pop: rd_ptr increments modulo depth.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, both pointers advance.
- Pointers wrap from depth-1 to 0. No other wrap handling is needed; count disambiguates full from empty.
- Boundary conditions:
  - Full: in_ready=0. in_valid is ignored for storage, and the producer must hold in_valid and in_data.
  - Empty: out_ready is ignored, and no pointer or count change occurs.
- Protocol rule: once in_valid=1 with in_ready=0, the producer must keep in_valid=1 until the word is accepted.
- ovf sets when the previous cycle had in_valid=1 & in_ready=0 and the current cycle has in_valid=0. ovf clears only on rst.
- Implementation tracks the stalled-valid condition with a single registered bit.
- rst mid-operation discards all stored words; count=0 takes effect immediately, without waiting for clk.
- Behaviour is fully synchronous to clk apart from rst.
- No X may propagate to in_ready, out_valid, count or ovf after reset.

Test Plan:
- Reset then idle, size=5, depth=4 -> count=0, out_valid=0, in_ready=1, ovf=0 for 10 cycles with in_valid=0.
- Push 5'h01, 5'h02, 5'h03, 5'h04 on consecutive cycles with out_ready=0:
  - count goes 1, 2, 3, 4; in_ready falls to 0 after the 4th push.
  - A 5th word 5'h1F held valid is not stored.
  - Then out_ready=1 pops 01, 02, 03, 04 in order, and 1F is accepted once in_ready returns.
- Concurrent push/pop at count=2 for 8 cycles with incrementing data:
  - count stays 2 and the output order is preserved.
  - Pointers wrap at least twice.
- Full with simultaneous out_ready=1 and in_valid=1 -> the pop happens and the push is rejected that cycle (count 4->3); the push succeeds next cycle (count 3->4).
- Producer asserts in_valid while full, then drops it before acceptance -> ovf=1 the following cycle and stays 1 until rst.
- Assert rst asynchronously, between clock edges, with count=3 -> count=0, out_valid=0, in_ready=1 before the next clk edge; the next push then appears as the head word.
